// File: rtl/micro_ondas_ctrl.sv
// Microwave controller: keypad MM:SS entry, start/stop/clear/door handling, 1 Hz countdown, 7-seg drive.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero minute digits.
module micro_ondas_ctrl #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] sec_ones_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] mins_segs,
    output logic [6:0] mins_tens_segs,
    output logic       mag_on
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   tm, tm_nxt, tm_dec;   // {mt, mo, st, so} BCD
    logic [PW-1:0] presc, presc_nxt;
    logic          key_q, startn_q;
    logic          key_any, key_evt, start_evt;
    logic [3:0]    key_val;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Highest set bit wins; an X/Z bit fails the if and so counts as not pressed.
    always_comb begin
        key_val = 4'd0;
        key_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                key_val = 4'(i);
                key_any = 1'b1;
            end
        end
    end

    assign key_evt   = key_any & ~key_q;
    assign start_evt = startn_q & ~startn;

    // One-second decrement with BCD borrow chain (st wraps to 5).
    always_comb begin
        tm_dec = tm;
        if (tm[3:0] != 4'd0) begin
            tm_dec[3:0] = tm[3:0] - 4'd1;
        end else begin
            tm_dec[3:0] = 4'd9;
            if (tm[7:4] != 4'd0) begin
                tm_dec[7:4] = tm[7:4] - 4'd1;
            end else begin
                tm_dec[7:4] = 4'd5;
                if (tm[11:8] != 4'd0) begin
                    tm_dec[11:8] = tm[11:8] - 4'd1;
                end else begin
                    tm_dec[11:8]  = 4'd9;
                    tm_dec[15:12] = tm[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tm       <= '0;
            presc    <= '0;
            key_q    <= 1'b0;
            startn_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            tm       <= tm_nxt;
            presc    <= presc_nxt;
            key_q    <= key_any;
            startn_q <= startn;
        end
    end

    always_comb begin
        state_nxt = state;
        tm_nxt    = tm;
        presc_nxt = presc;
        if (!clearn) begin
            state_nxt = IDLE;
            tm_nxt    = '0;
        end else begin
            case (state)
                COOK: begin
                    if (!stopn || !door_closed) begin
                        state_nxt = PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc_nxt = '0;
                        tm_nxt    = tm_dec;
                        if (tm_dec == 16'h0000) state_nxt = IDLE;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                default: begin
                    if (start_evt && door_closed && stopn && (tm != 16'h0000)) begin
                        state_nxt = COOK;
                        presc_nxt = '0;
                    end else if (key_evt) begin
                        tm_nxt = {tm[11:0], key_val};
                    end
                end
            endcase
        end
    end

    always_comb begin
        mag_on        = (state == COOK);
        sec_ones_segs = seg7(tm[3:0]);
        sec_tens_segs = seg7(tm[7:4]);
        mins_segs     = seg7(tm[11:8]);
        mins_tens_segs = seg7(tm[15:12]);
`ifdef LEADING_ZERO_BLANK_EN
        if (tm[15:12] == 4'd0) begin
            mins_tens_segs = 7'h00;
            if (tm[11:8] == 4'd0) mins_segs = 7'h00;
        end
`endif
    end

endmodule

// File: tb/tb_micro_ondas_ctrl.sv
// Directed bench for micro_ondas_ctrl: entry, cook countdown, pause, door, clear and reset.
module tb_micro_ondas_ctrl;

    logic       clock = 1'b0;
    logic       reset, startn, stopn, clearn, door_closed;
    logic [9:0] keypad;
    logic [6:0] sec_ones_segs, sec_tens_segs, mins_segs, mins_tens_segs;
    logic       mag_on;

    int passed = 0;
    int total  = 0;

    micro_ondas_ctrl #(.TICKS_PER_SEC(100)) dut (
        .clock(clock), .reset(reset), .keypad(keypad), .startn(startn),
        .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs),
        .mins_segs(mins_segs), .mins_tens_segs(mins_tens_segs), .mag_on(mag_on)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h3F; 1: seg = 7'h06; 2: seg = 7'h5B; 3: seg = 7'h4F;
            4: seg = 7'h66; 5: seg = 7'h6D; 6: seg = 7'h7D; 7: seg = 7'h07;
            8: seg = 7'h7F; 9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input int mt, input int mo, input int st, input int so,
                       input logic mag);
        logic [28:0] obs, exp;
        obs = {mins_tens_segs, mins_segs, sec_tens_segs, sec_ones_segs, mag_on};
        exp = {seg(mt), seg(mo), seg(st), seg(so), mag};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic press(input int k);
        keypad = '0;
        keypad[k] = 1'b1;
        step(10);
        keypad = '0;
        step(1);
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        step(1);
    endtask

    initial begin
        reset = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1;
        step(2);
        chk("reset", 0, 0, 0, 0, 1'b0);
        reset = 1'b0;
        step(1);

        // entry 01:35
        press(1); press(3); press(5);
        chk("entry_0135", 0, 1, 3, 5, 1'b0);

        // cook and count down
        start_pulse();
        chk("start_mag", 0, 1, 3, 5, 1'b1);
        step(99);
        chk("before_tick", 0, 1, 3, 5, 1'b1);
        step(1);
        chk("tick_0134", 0, 1, 3, 4, 1'b1);
        step(3400);
        chk("at_0100", 0, 1, 0, 0, 1'b1);
        step(100);
        chk("borrow_0059", 0, 0, 5, 9, 1'b1);

        // keypad ignored while cooking, stop pauses, start resumes
        press(2);
        chk("key_ignored", 0, 0, 5, 9, 1'b1);
        stopn = 1'b0;
        step(1);
        chk("stop_pause", 0, 0, 5, 9, 1'b0);
        step(5);
        chk("pause_held", 0, 0, 5, 9, 1'b0);
        stopn = 1'b1;
        start_pulse();
        chk("resume_mag", 0, 0, 5, 9, 1'b1);
        step(99);
        chk("resume_presc_clr", 0, 0, 5, 9, 1'b1);
        step(1);
        chk("resume_tick", 0, 0, 5, 8, 1'b1);

        // door open pauses; start with door open ignored
        door_closed = 1'b0;
        step(1);
        chk("door_pause", 0, 0, 5, 8, 1'b0);
        start_pulse();
        step(1);
        chk("start_door_open", 0, 0, 5, 8, 1'b0);
        door_closed = 1'b1;
        step(1);
        start_pulse();
        chk("door_resume", 0, 0, 5, 8, 1'b1);
        step(100);
        chk("door_resume_tick", 0, 0, 5, 7, 1'b1);

        // clear mid-cook
        clearn = 1'b0;
        step(1);
        chk("clear_cook", 0, 0, 0, 0, 1'b0);
        clearn = 1'b1;
        step(1);
        start_pulse();
        step(1);
        chk("start_at_zero", 0, 0, 0, 0, 1'b0);

        // 00:01 runs out to IDLE
        press(1);
        start_pulse();
        chk("cook_0001", 0, 0, 0, 1, 1'b1);
        step(99);
        chk("cook_0001_hold", 0, 0, 0, 1, 1'b1);
        step(1);
        chk("done_idle", 0, 0, 0, 0, 1'b0);
        start_pulse();
        step(1);
        chk("done_restart_ign", 0, 0, 0, 0, 1'b0);

        // 10:00 -> 09:59
        press(1); press(0); press(0); press(0);
        chk("entry_1000", 1, 0, 0, 0, 1'b0);
        start_pulse();
        step(100);
        chk("borrow_0959", 0, 9, 5, 9, 1'b1);
        do_clear();

        // 00:99 -> 00:98 (st above 5 at entry)
        press(9); press(9);
        start_pulse();
        step(100);
        chk("tick_0098", 0, 0, 9, 8, 1'b1);
        do_clear();

        // highest key wins; start with stop held ignored
        keypad = 10'b01_0000_1000;
        step(10);
        keypad = '0;
        step(1);
        chk("multi_key", 0, 0, 0, 8, 1'b0);
        stopn = 1'b0;
        start_pulse();
        step(1);
        chk("start_stop_held", 0, 0, 0, 8, 1'b0);
        stopn = 1'b1;
        step(1);

        // shift discards mt; reset mid-entry
        press(4); press(2);
        chk("shift_0842", 0, 8, 4, 2, 1'b0);
        keypad = 10'b00_1000_0000;
        step(3);
        reset = 1'b1;
        step(1);
        chk("reset_mid_entry", 0, 0, 0, 0, 1'b0);
        reset = 1'b0;
        keypad = '0;
        step(2);
        chk("after_reset", 0, 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
